// File: rtl/rptr_fwft.sv
// Read-side pointer, empty/almost-empty flags and first-word-fall-through prefetch
// for the dual-clock FIFO (rclk domain). Define RPTR_FWFT_FLUSH_EN to add the rflush port.
module rptr_fwft #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rmem_en,
  input  logic [DATA_WIDTH-1:0] rmem_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH:0]   rlevel
`ifdef RPTR_FWFT_FLUSH_EN
  ,
  input  logic                  rflush
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic                  flush;
`ifdef RPTR_FWFT_FLUSH_EN
  assign flush = rflush;
`else
  assign flush = 1'b0;
`endif

  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  pend_q, pend_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  rempty_q, rempty_d;
  logic                  raempty_q, raempty_d;
  logic [PW-1:0]         rlevel_q, rlevel_d;

  logic [PW-1:0]         wbin;
  logic [PW-1:0]         level_next;
  logic                  mem_avail;
  logic                  fetch;

  always_comb begin
    // NOTE: every output gets a value before any branch, so no latch can be inferred.
    wbin       = gray2bin(rq2_wptr);
    mem_avail  = (rptr_q != rq2_wptr);
    // Fetch only when the output register is free or being emptied this cycle.
    fetch      = mem_avail & (~rvalid_q | rready) & ~flush;

    rbin_d     = flush ? wbin : rbin_q + PW'(fetch);
    rptr_d     = (rbin_d >> 1) ^ rbin_d;
    level_next = wbin - rbin_d;

    pend_d     = fetch;
    rvalid_d   = fetch | (rvalid_q & ~rready);
    hold_d     = pend_q ? rmem_data : hold_q;
    rempty_d   = (rptr_d == rq2_wptr);
    rlevel_d   = level_next;
    raempty_d  = (level_next <= THRESH);

    if (flush) begin
      rvalid_d  = 1'b0;
      hold_d    = '0;
      rempty_d  = 1'b1;
      rlevel_d  = '0;
      raempty_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop sees
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      pend_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      // NOTE: the hold register is a single data word, not an array, so resetting
      // it is cheap and guarantees no stale word survives a reset.
      hold_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rlevel_q  <= '0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      pend_q    <= pend_d;
      rvalid_q  <= rvalid_d;
      hold_q    <= hold_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      rlevel_q  <= rlevel_d;
    end
  end

  // The strobe is gated by reset because rq2_wptr may already be nonzero in reset.
  assign rmem_en = fetch & rrst_n;
  assign raddr   = rbin_q[ADDR_WIDTH-1:0];
  assign rptr    = rptr_q;
  assign rdata   = pend_q ? rmem_data : hold_q;
  assign rvalid  = rvalid_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_fwft.sv
// Self-checking bench for rptr_fwft: random traffic, count-based reference model,
// and a data scoreboard popped by an independent output monitor.
module tb_rptr_fwft;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic [PW-1:0] rq2_wptr = '0;
  logic [PW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic          rmem_en;
  logic [DW-1:0] rmem_data = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          rempty;
  logic          raempty;
  logic [PW-1:0] rlevel;
`ifdef RPTR_FWFT_FLUSH_EN
  logic          rflush = 1'b0;
`endif

  rptr_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AEMPTY_THRESH(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rptr      (rptr),
    .raddr     (raddr),
    .rmem_en   (rmem_en),
    .rmem_data (rmem_data),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel)
`ifdef RPTR_FWFT_FLUSH_EN
    ,
    .rflush    (rflush)
`endif
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int unsigned b);
    logic [PW-1:0] x;
    x = b[PW-1:0];
    return x ^ (x >> 1);
  endfunction

  // Memory with one-cycle synchronous read, written directly by the stimulus.
  logic [DW-1:0] mem [16];
  always @(posedge rclk) if (rmem_en) rmem_data <= mem[raddr];

  // Reference model in word counts: written, taken from memory, output occupied.
  int unsigned tb_w = 0;
  int unsigned m_w  = 0;
  int unsigned m_f  = 0;
  bit          m_mv = 1'b0;
  logic [DW-1:0] exp_q [$];

  always @(posedge rclk) begin
    bit can;
    if (!rrst_n) begin
      m_w = 0; m_f = 0; m_mv = 1'b0;
    end else begin
      m_w = tb_w;
`ifdef RPTR_FWFT_FLUSH_EN
      if (rflush) begin
        m_f = tb_w; m_mv = 1'b0;
      end else
`endif
      begin
        can  = (tb_w > m_f) && (!m_mv || rready);
        m_mv = can || (m_mv && !rready);
        if (can) m_f++;
      end
    end
  end

  // Output monitor: flags, pointer, strobe, stability and in-order data.
  logic [DW-1:0] prev_data = '0;
  bit            prev_hold = 1'b0;
  always @(negedge rclk) begin
    logic [PW-1:0] lvl;
    bit            exp_en;
    bit            flushing;
    if (!rrst_n) begin
      prev_hold = 1'b0;
    end else begin
      flushing = 1'b0;
`ifdef RPTR_FWFT_FLUSH_EN
      flushing = rflush;
`endif
      lvl    = PW'(m_w - m_f);
      exp_en = (tb_w > m_f) && (!m_mv || rready) && !flushing;
      check("rvalid", rvalid, m_mv);
      check("rlevel", rlevel, lvl);
      check("rempty", rempty, lvl == 0);
      check("raempty", raempty, lvl <= 4);
      check("rptr", rptr, gray(m_f));
      check("rmem_en", rmem_en, exp_en);
      if (exp_en) check("raddr", raddr, m_f % 16);
      if (prev_hold) check("rdata_stable", rdata, prev_data);
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_word: got %0h expected no word at %0t", rdata, $time);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end
      prev_hold = rvalid && !rready && !flushing;
      prev_data = rdata;
    end
  end

  task automatic tick;
    @(posedge rclk);
    #2;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[tb_w % 16] = d;
    exp_q.push_back(d);
    tb_w++;
    rq2_wptr = gray(tb_w);
  endtask

  task automatic drain(input int budget);
    bit done;
    rready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      done = (exp_q.size() == 0) && (m_f == tb_w) && !m_mv;
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int written;
    bit done;
    // Reset state, held across several edges.
    #1 rrst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_rptr", rptr, 0);
      check("rst_raddr", raddr, 0);
      check("rst_rmem_en", rmem_en, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rempty", rempty, 1);
      check("rst_raempty", raempty, 1);
      check("rst_rlevel", rlevel, 0);
      @(negedge rclk);
    end
    rrst_n = 1'b1;

    // Streaming: three words A, B, C.
    tick();
    rready = 1'b1;
    write_word(16'hA0A0);
    write_word(16'hB0B1);
    write_word(16'hC0C2);
    drain(20);
    check("stream_rptr", rptr, 5'b00010);

    // Backpressure: six words, consumer stalled.
    rready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(16'h1100 + 16'(i));
    repeat (12) tick();
    check("bp_rvalid", rvalid, 1);
    check("bp_rlevel", rlevel, 5);
    check("bp_raempty", raempty, 0);
    check("bp_rdata", rdata, 16'h1100);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("bp_rlevel_after", rlevel, 4);
    check("bp_raempty_after", raempty, 1);
    drain(40);

    // Wrap: 40 random words with random rready, pointer crosses 16/32/48.
    written = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      rready = ($urandom % 4) != 0;
      if (written < 40 && ($urandom % 2) == 1) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          if (written < 40 && (tb_w - m_f) < 16) begin
            write_word(16'($urandom));
            written++;
          end
        end
      end
      tick();
      done = (written == 40) && (exp_q.size() == 0) && (m_f == tb_w) && !m_mv;
    end
    check("wrap_done", done, 1);
    check("wrap_rempty", rempty, 1);

`ifdef RPTR_FWFT_FLUSH_EN
    // Flush: eight words, accept one, then discard the rest.
    rready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(16'h5500 + 16'(i));
    repeat (3) tick();
    rready = 1'b1;
    tick();
    rready = 1'b0;
    repeat (2) tick();
    rflush = 1'b1;
    exp_q.delete();
    tick();
    rflush = 1'b0;
    check("fl_rvalid", rvalid, 0);
    check("fl_rempty", rempty, 1);
    check("fl_rlevel", rlevel, 0);
    check("fl_rptr", rptr, rq2_wptr);
    rready = 1'b1;
    write_word(16'h6666);
    #3;
    check("fl_refetch_en", rmem_en, 1);
    check("fl_refetch_addr", raddr, (tb_w - 1) % 16);
    drain(20);
`endif

    // Reset mid-stream with a word in flight.
    rready = 1'b1;
    for (int i = 0; i < 4; i++) write_word(16'h7700 + 16'(i));
    tick();
    check("mid_pre_rvalid", rvalid, 1);
    rrst_n = 1'b0;
    #1;
    check("mid_rptr", rptr, 0);
    check("mid_raddr", raddr, 0);
    check("mid_rmem_en", rmem_en, 0);
    check("mid_rvalid", rvalid, 0);
    check("mid_rempty", rempty, 1);
    check("mid_raempty", raempty, 1);
    check("mid_rlevel", rlevel, 0);
    check("mid_rdata", rdata, 0);
    tb_w = 0;
    rq2_wptr = '0;
    exp_q.delete();
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) write_word(16'h8800 + 16'(i));
    drain(20);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
